// File: rtl/dbg_frame_tx_sched.sv
// dbg_frame_tx_sched: captures a probe snapshot on trig and streams sync, data (MSB first), checksum over valid/ready
module dbg_frame_tx_sched #(
  parameter int NBYTES = 12,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                  CLK100MHZ,
  input  logic                  rst_n,
  input  logic                  trig,
  input  logic [8*NBYTES-1:0]   frame_in,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  dropped,
  output logic [7:0]            frame_cnt
);
  localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  typedef enum logic [1:0] {IDLE, SYNC, DATA, SUM} state_t;
  state_t state;
  logic [8*NBYTES-1:0] shadow;
  logic [IW-1:0] idx, nidx;
  logic [7:0] sum, nsum;
  assign nidx = idx - IW'(1);
  assign nsum = sum + tx_data;
  // tx_valid is high in every non-IDLE state, so tx_ready alone marks a transfer there
  always_ff @(posedge CLK100MHZ) begin
    if (!rst_n) begin
      state     <= IDLE;
      shadow    <= '0;
      idx       <= '0;
      sum       <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      dropped   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      dropped <= trig && state != IDLE;
      case (state)
        IDLE: if (trig) begin
          shadow   <= frame_in;
          idx      <= IW'(NBYTES - 1);
          sum      <= '0;
          tx_data  <= SYNC_BYTE;
          tx_valid <= 1'b1;
          busy     <= 1'b1;
          state    <= SYNC;
        end
        SYNC: if (tx_ready) begin
          tx_data <= shadow[{idx, 3'b000} +: 8];
          state   <= DATA;
        end
        DATA: if (tx_ready) begin
          sum <= nsum;
          if (idx == '0) begin
            tx_data <= -nsum;
            state   <= SUM;
          end else begin
            idx     <= nidx;
            tx_data <= shadow[{nidx, 3'b000} +: 8];
          end
        end
        SUM: if (tx_ready) begin
          tx_valid  <= 1'b0;
          busy      <= 1'b0;
          frame_cnt <= frame_cnt + 8'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dbg_frame_tx_sched.sv
// tb_dbg_frame_tx_sched: byte-queue reference model checked every cycle, plus directed literal expectations
module tb_dbg_frame_tx_sched;
  localparam int NB = 12;
  localparam logic [95:0] F1 = 96'h0102030405060708090A0B0C;
  localparam logic [95:0] F2 = 96'hDEADBEEF001122338899AABB;
  logic clk = 1'b0, rst_n = 1'b0, trig = 1'b0, tx_ready = 1'b1;
  logic [8*NB-1:0] frame_in = '0;
  logic [7:0] tx_data, frame_cnt;
  logic tx_valid, busy, dropped;
  int n_chk = 0, n_fail = 0, cyc;
  byte unsigned exp_q[$], log_q[$], e1[$], e3[$];
  logic [7:0] m_cnt = '0;
  logic m_drop = 1'b0, m_zero = 1'b0, armed = 1'b0, saw_drop = 1'b0, was_busy;

  dbg_frame_tx_sched #(.NBYTES(NB), .SYNC_BYTE(8'hA5)) dut (
    .CLK100MHZ(clk), .rst_n(rst_n), .trig(trig), .frame_in(frame_in),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .dropped(dropped), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void build_frame(input logic [8*NB-1:0] f);
    int s = 0;
    exp_q.push_back(8'hA5);
    for (int i = NB - 1; i >= 0; i--) begin
      exp_q.push_back(f[8*i +: 8]);
      s += int'(f[8*i +: 8]);
    end
    exp_q.push_back(8'((256 - (s % 256)) % 256));
  endfunction

  // Reference model: a frame is just a queue of bytes still owed to the UART
  always @(negedge clk) begin
    if (armed) begin
      check("busy", 32'(busy), 32'(exp_q.size() > 0));
      check("tx_valid", 32'(tx_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) check("tx_data", 32'(tx_data), 32'(exp_q[0]));
      check("dropped", 32'(dropped), 32'(m_drop));
      check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
      if (m_zero) check("tx_data_rst", 32'(tx_data), 32'h0);
    end
    if (dropped) saw_drop = 1'b1;
    if (tx_valid && tx_ready && rst_n) log_q.push_back(tx_data);
    m_zero = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      m_cnt = '0;
      m_drop = 1'b0;
      m_zero = 1'b1;
      armed = 1'b1;
    end else begin
      was_busy = exp_q.size() > 0;
      m_drop = trig && was_busy;
      if (was_busy && tx_ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) m_cnt = m_cnt + 8'd1;
      end
      if (trig && !was_busy) build_frame(frame_in);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_frame(input logic [95:0] f, input byte unsigned stall_b, input int stall_n, output int c);
    log_q.delete();
    frame_in = f;
    trig = 1'b1;
    step();
    trig = 1'b0;
    frame_in = '0;
    c = 0;
    while (busy && c < 200) begin
      if (stall_n > 0 && tx_valid && tx_data == stall_b) begin
        tx_ready = 1'b0;
        stall_n--;
        step();
        c++;
        check("stall_hold", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, stall_b});
      end else begin
        tx_ready = 1'b1;
        step();
        c++;
      end
    end
    tx_ready = 1'b1;
    if (busy) check("frame_timeout", 32'(busy), 32'h0);
  endtask

  task automatic check_log(input string name, input byte unsigned e[$]);
    check({name, "_len"}, 32'(log_q.size()), 32'(e.size()));
    foreach (e[i]) if (i < log_q.size()) check(name, 32'(log_q[i]), 32'(e[i]));
  endtask

  initial begin
    e1 = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'hB2};
    e3.push_back(8'hA5);
    repeat (NB) e3.push_back(8'hFF);
    e3.push_back(8'h0C);
    step(2);
    rst_n = 1'b1;
    check("rst_valid", 32'(tx_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_data", 32'(tx_data), 0);
    check("rst_cnt", 32'(frame_cnt), 0);
    check("rst_drop", 32'(dropped), 0);
    // 1: streaming frame
    run_frame(F1, 8'h00, 0, cyc);
    check("t1_cycles", 32'(cyc), 14);
    check_log("t1_bytes", e1);
    check("t1_cnt", 32'(frame_cnt), 1);
    // 2: backpressure on byte 05
    run_frame(F1, 8'h05, 3, cyc);
    check("t2_cycles", 32'(cyc), 17);
    check_log("t2_bytes", e1);
    check("t2_cnt", 32'(frame_cnt), 2);
    // 3: all-ones snapshot, input cleared after trig
    run_frame({NB{8'hFF}}, 8'h00, 0, cyc);
    check_log("t3_bytes", e3);
    check("t3_cnt", 32'(frame_cnt), 3);
    // 4: overlapping triggers mid-frame and in the SUM transfer cycle
    log_q.delete();
    frame_in = F1;
    trig = 1'b1;
    step();
    trig = 1'b0;
    frame_in = '0;
    step(5);
    trig = 1'b1;
    step();
    trig = 1'b0;
    check("t4_drop1", 32'(dropped), 1);
    step();
    check("t4_drop1_end", 32'(dropped), 0);
    step(6);
    check("t4_sum_offer", 32'(tx_data), 32'hB2);
    trig = 1'b1;
    step();
    trig = 1'b0;
    check("t4_drop2", 32'(dropped), 1);
    check("t4_idle", 32'(busy), 0);
    step();
    check("t4_drop2_end", 32'(dropped), 0);
    check_log("t4_bytes", e1);
    check("t4_cnt", 32'(frame_cnt), 4);
    // 5: reset during DATA, then a clean frame
    frame_in = F1;
    trig = 1'b1;
    step();
    trig = 1'b0;
    step(5);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t5_valid", 32'(tx_valid), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_cnt", 32'(frame_cnt), 0);
    run_frame(F2, 8'h00, 0, cyc);
    check("t5_cycles", 32'(cyc), 14);
    check("t5_len", 32'(log_q.size()), 14);
    if (log_q.size() == 14) check("t5_csum", 32'(log_q[13]), 32'hDC);
    check("t5_cnt1", 32'(frame_cnt), 1);
    // 6: 256 back-to-back frames
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    saw_drop = 1'b0;
    for (int i = 0; i < 256; i++) begin
      run_frame(F1, 8'h00, 0, cyc);
      if (i == 254) check("t6_cnt255", 32'(frame_cnt), 32'hFF);
    end
    check("t6_wrap", 32'(frame_cnt), 0);
    check("t6_no_drop", 32'(saw_drop), 0);
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
